past_history_buf: RTL

Synthesizable hardware equivalent of the gated `$past(sig, N, en)` operator. It keeps a circular history of the last DEPTH enabled samples of a WIDTH-bit input. Any history entry can be selected at run time by a tap index, and a validity flag reports whether that entry exists yet. The block sits beside design logic as an on-chip checker and trace source, mirroring what our assertion benches compute with `$past`.

---
 rtl/past_hist_pkg.sv | 16 +
 rtl/past_hist_edge.sv | 21 ++
 rtl/past_history_buf.sv | 86 ++++++++
 3 files changed

// File: rtl/past_hist_pkg.sv
// Shared helpers for past_history_buf: tap width and modulo history index.
package past_hist_pkg;

  function automatic int tap_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // (wp - tap) mod depth with add-back, no power-of-two overflow assumed
  function automatic int wrap_sub(input int wp, input int tap, input int depth);
    int diff;
    diff = wp - tap;
    if (diff < 0) diff = diff + depth;
    return diff;
  endfunction

endpackage

// File: rtl/past_hist_edge.sv
// Edge/change detector of din against the most recent stored history sample.
module past_hist_edge #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] last,
  input  logic             en,
  output logic             rose,
  output logic             fell,
  output logic             changed,
  output logic             stable
);

  always_comb begin
    rose    = en & ~last[0] & din[0];
    fell    = en & last[0] & ~din[0];
    changed = en & (din != last);
    stable  = ~en | (din == last);
  end

endmodule

// File: rtl/past_history_buf.sv
// Gated $past(sig, N, en) history buffer with run-time tap selection.
// Define PAST_HIST_EDGE_EN to add rose_o/fell_o/changed_o/stable_o outputs.
module past_history_buf
  import past_hist_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              TAP_W     = tap_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [TAP_W-1:0] tap,
  output logic [WIDTH-1:0] past_out,
  output logic             past_valid,
  output logic             tap_err,
`ifdef PAST_HIST_EDGE_EN
  output logic             rose_o,
  output logic             fell_o,
  output logic             changed_o,
  output logic             stable_o,
`endif
  output logic [TAP_W-1:0] fill_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [TAP_W-1:0] FILL_MAX = TAP_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [TAP_W-1:0] r_fill;

  logic [PTR_W-1:0] w_idx;
  logic             w_err;
  logic             w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_wp   <= (r_wp == PTR_LAST) ? '0 : r_wp + 1'b1;
      if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
    end
  end

  // Storage is deliberately unreset; past_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (!rst && en) r_mem[r_wp] <= din;
  end

  always_comb begin
    w_err    = (tap == '0) || (tap > FILL_MAX);
    w_valid  = !w_err && (tap <= r_fill);
    w_idx    = w_err ? '0 : PTR_W'(wrap_sub(int'(r_wp), int'(tap), DEPTH));
    past_out = w_valid ? r_mem[w_idx] : RESET_VAL;
  end

  assign past_valid = w_valid;
  assign tap_err    = w_err;
  assign fill_cnt   = r_fill;

`ifdef PAST_HIST_EDGE_EN
  logic [PTR_W-1:0] w_last_idx;
  logic [WIDTH-1:0] w_last;

  always_comb begin
    w_last_idx = PTR_W'(wrap_sub(int'(r_wp), 1, DEPTH));
    w_last     = (r_fill == '0) ? RESET_VAL : r_mem[w_last_idx];
  end

  past_hist_edge #(.WIDTH(WIDTH)) u_edge (
    .din     (din),
    .last    (w_last),
    .en      (en),
    .rose    (rose_o),
    .fell    (fell_o),
    .changed (changed_o),
    .stable  (stable_o)
  );
`endif

endmodule
